// File: rtl/deflect_route_stage_pkg.sv
// rtl/deflect_route_stage_pkg.sv - shared router constants, direction encoding and helpers
package deflect_route_stage_pkg;

    typedef logic [5:0] addr_t;
    typedef logic [4:0] dir_t;

    // Output port indices; they match the bit positions of the one-hot direction code
    localparam int PORT_E = 0;
    localparam int PORT_W = 1;
    localparam int PORT_N = 2;
    localparam int PORT_S = 3;

    // Input slot indices as they leave the injector
    localparam int SLOT_N = 0;
    localparam int SLOT_S = 1;
    localparam int SLOT_E = 2;
    localparam int SLOT_W = 3;

    localparam dir_t DIR_E = 5'b00001;
    localparam dir_t DIR_W = 5'b00010;
    localparam dir_t DIR_N = 5'b00100;
    localparam dir_t DIR_S = 5'b01000;
    localparam dir_t DIR_L = 5'b10000;

    // Address field positions: row in the upper half, column in the lower half
    localparam int ROW_HI = 5;
    localparam int ROW_LO = 3;
    localparam int COL_HI = 2;
    localparam int COL_LO = 0;

    // Link direction to output port index; local has no port and maps to east
    function automatic logic [1:0] dir_to_port(input dir_t d);
        logic [1:0] p;
        case (d)
            DIR_W:   p = 2'(PORT_W);
            DIR_N:   p = 2'(PORT_N);
            DIR_S:   p = 2'(PORT_S);
            default: p = 2'(PORT_E);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/deflect_route_stage_if.sv
// rtl/deflect_route_stage_if.sv - slot inputs and link outputs of the deflection route stage
interface deflect_route_stage_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       nad, sad, ead, wad;
    logic             nvalid, svalid, evalid, wvalid;
    logic [5:0]       eout, wout, nout, sout;
    logic             eout_v, wout_v, nout_v, sout_v;
    logic [CNT_W-1:0] deflect_cnt;
    logic [1:0]       epoch;

    modport master (
        output nad, sad, ead, wad, nvalid, svalid, evalid, wvalid,
        input  eout, wout, nout, sout, eout_v, wout_v, nout_v, sout_v,
        input  deflect_cnt, epoch
    );

    modport slave (
        input  nad, sad, ead, wad, nvalid, svalid, evalid, wvalid,
        output eout, wout, nout, sout, eout_v, wout_v, nout_v, sout_v,
        output deflect_cnt, epoch
    );
endinterface

// File: rtl/deflect_route_stage_xy_route.sv
// rtl/deflect_route_stage_xy_route.sv - column-first XY routing of one address to a one-hot direction
module xy_route
    import deflect_route_stage_pkg::*;
#(
    parameter logic [2:0] MY_ROW = 3'd4,
    parameter logic [2:0] MY_COL = 3'd4
) (
    input  addr_t addr_i,
    output dir_t  dir_o
);
    logic [2:0] row;
    logic [2:0] col;

    assign row = addr_i[ROW_HI:ROW_LO];
    assign col = addr_i[COL_HI:COL_LO];

    // Resolve the column first, then the row; a full match means the flit is home
    always_comb begin
        if (col > MY_COL)      dir_o = DIR_E;
        else if (col < MY_COL) dir_o = DIR_W;
        else if (row > MY_ROW) dir_o = DIR_N;
        else if (row < MY_ROW) dir_o = DIR_S;
        else                   dir_o = DIR_L;
    end
endmodule

// File: rtl/deflect_route_stage.sv
// rtl/deflect_route_stage.sv - rotating-priority port allocation with deflection and registered links
module deflect_route_stage
    import deflect_route_stage_pkg::*;
#(
    parameter logic [2:0] MY_ROW        = 3'd4,
    parameter logic [2:0] MY_COL        = 3'd4,
    parameter int         GOLDEN_PERIOD = 16,
    parameter int         CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    deflect_route_stage_if.slave  bus
);
    localparam int                CYC_W    = (GOLDEN_PERIOD > 1) ? $clog2(GOLDEN_PERIOD) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(GOLDEN_PERIOD - 1);

    addr_t            slot_addr [4];
    logic [3:0]       slot_v;
    dir_t             slot_dir  [4];

    addr_t            out_addr_q [4];
    addr_t            out_addr_d [4];
    logic [3:0]       out_v_q;
    logic [3:0]       out_v_d;
    logic [2:0]       defl_n_d;
    logic [1:0]       s_idx;
    logic [1:0]       want_port;
    logic             found;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_sum;
    logic [CYC_W-1:0] cyc_q;
    logic [1:0]       epoch_q;

    assign slot_addr[SLOT_N] = bus.nad;
    assign slot_addr[SLOT_S] = bus.sad;
    assign slot_addr[SLOT_E] = bus.ead;
    assign slot_addr[SLOT_W] = bus.wad;
    assign slot_v = {bus.wvalid, bus.evalid, bus.svalid, bus.nvalid};

    for (genvar g = 0; g < 4; g++) begin : g_route
        xy_route #(.MY_ROW(MY_ROW), .MY_COL(MY_COL)) u_xy_route (
            .addr_i (slot_addr[g]),
            .dir_o  (slot_dir[g])
        );
    end

    // Walk slots in epoch-rotated order; each valid flit takes its desired port or the lowest free one
    always_comb begin
        out_v_d   = '0;
        defl_n_d  = '0;
        s_idx     = '0;
        want_port = '0;
        found     = 1'b0;
        for (int p = 0; p < 4; p++) out_addr_d[p] = '0;
        for (int k = 0; k < 4; k++) begin
            s_idx     = epoch_q + 2'(k);
            want_port = dir_to_port(slot_dir[s_idx]);
            if (slot_v[s_idx]) begin
                if (slot_dir[s_idx] != DIR_L && !out_v_d[want_port]) begin
                    out_v_d[want_port]    = 1'b1;
                    out_addr_d[want_port] = slot_addr[s_idx];
                end else begin
                    found = 1'b0;
                    for (int p = 0; p < 4; p++) begin
                        if (!found && !out_v_d[p]) begin
                            out_v_d[p]    = 1'b1;
                            out_addr_d[p] = slot_addr[s_idx];
                            found         = 1'b1;
                        end
                    end
                    defl_n_d = defl_n_d + 3'd1;
                end
            end
        end
    end

    // Deflection count clamps at all-ones instead of wrapping
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(defl_n_d);
        cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Output links, deflection counter and golden-epoch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q <= '0;
            for (int p = 0; p < 4; p++) out_addr_q[p] <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            epoch_q <= '0;
        end else begin
            out_v_q <= out_v_d;
            for (int p = 0; p < 4; p++) out_addr_q[p] <= out_addr_d[p];
            cnt_q   <= cnt_d;
            if (cyc_q == CYC_LAST) begin
                cyc_q   <= '0;
                epoch_q <= epoch_q + 2'd1;
            end else begin
                cyc_q   <= cyc_q + CYC_W'(1);
            end
        end
    end

    assign bus.eout        = out_addr_q[PORT_E];
    assign bus.wout        = out_addr_q[PORT_W];
    assign bus.nout        = out_addr_q[PORT_N];
    assign bus.sout        = out_addr_q[PORT_S];
    assign bus.eout_v      = out_v_q[PORT_E];
    assign bus.wout_v      = out_v_q[PORT_W];
    assign bus.nout_v      = out_v_q[PORT_N];
    assign bus.sout_v      = out_v_q[PORT_S];
    assign bus.deflect_cnt = cnt_q;
    assign bus.epoch       = epoch_q;
endmodule

// File: tb/tb_deflect_route_stage.sv
// tb/tb_deflect_route_stage.sv - randomized and directed checks of deflect_route_stage against a reference model
module tb_deflect_route_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deflect_route_stage_if #(.CNT_W(16)) ifa ();
    deflect_route_stage_if #(.CNT_W(4))  ifb ();

    deflect_route_stage #(.MY_ROW(3'd4), .MY_COL(3'd4), .GOLDEN_PERIOD(16), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    deflect_route_stage #(.MY_ROW(3'd4), .MY_COL(3'd4), .GOLDEN_PERIOD(16), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;

    // Stimulus, slot order N, S, E, W
    logic [5:0] in_addr [4];
    logic       in_v    [4];

    // Reference state, port order E, W, N, S
    logic [5:0] m_addr [4];
    logic       m_v    [4];
    int         m_cnt16, m_cnt4, m_epoch, m_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int desired(input logic [5:0] a);
        int row, col;
        row = int'(a[5:3]);
        col = int'(a[2:0]);
        if (col > 4) return 0;
        if (col < 4) return 1;
        if (row > 4) return 2;
        if (row < 4) return 3;
        return 4;
    endfunction

    task automatic model_edge(input logic r);
        bit taken [4];
        int s, d, p, nd;
        for (int q = 0; q < 4; q++) begin
            m_addr[q] = 6'd0;
            m_v[q]    = 1'b0;
            taken[q]  = 1'b0;
        end
        if (r) begin
            m_cnt16 = 0; m_cnt4 = 0; m_epoch = 0; m_cyc = 0;
        end else begin
            nd = 0;
            for (int k = 0; k < 4; k++) begin
                s = (m_epoch + k) % 4;
                if (in_v[s]) begin
                    d = desired(in_addr[s]);
                    if (d < 4 && !taken[d]) p = d;
                    else begin
                        p = -1;
                        for (int q = 3; q >= 0; q--) if (!taken[q]) p = q;
                        nd++;
                    end
                    taken[p]  = 1'b1;
                    m_v[p]    = 1'b1;
                    m_addr[p] = in_addr[s];
                end
            end
            m_cnt16 = (m_cnt16 + nd > 65535) ? 65535 : m_cnt16 + nd;
            m_cnt4  = (m_cnt4 + nd > 15) ? 15 : m_cnt4 + nd;
            m_cyc++;
            if (m_cyc == 16) begin
                m_cyc   = 0;
                m_epoch = (m_epoch + 1) % 4;
            end
        end
    endtask

    task automatic apply();
        ifa.nad = in_addr[0]; ifa.sad = in_addr[1]; ifa.ead = in_addr[2]; ifa.wad = in_addr[3];
        ifa.nvalid = in_v[0]; ifa.svalid = in_v[1]; ifa.evalid = in_v[2]; ifa.wvalid = in_v[3];
        ifb.nad = in_addr[0]; ifb.sad = in_addr[1]; ifb.ead = in_addr[2]; ifb.wad = in_addr[3];
        ifb.nvalid = in_v[0]; ifb.svalid = in_v[1]; ifb.evalid = in_v[2]; ifb.wvalid = in_v[3];
    endtask

    task automatic set_slots(input logic [3:0] v, input logic [5:0] n, input logic [5:0] s,
                             input logic [5:0] e, input logic [5:0] w);
        in_addr[0] = n; in_addr[1] = s; in_addr[2] = e; in_addr[3] = w;
        for (int i = 0; i < 4; i++) in_v[i] = v[i];
        apply();
    endtask

    task automatic set_random();
        for (int i = 0; i < 4; i++) begin
            in_addr[i] = 6'($urandom_range(0, 63));
            in_v[i]    = 1'($urandom_range(0, 1));
        end
        apply();
    endtask

    task automatic compare_all();
        chk("a_eout",   32'(ifa.eout),   32'(m_addr[0]));
        chk("a_wout",   32'(ifa.wout),   32'(m_addr[1]));
        chk("a_nout",   32'(ifa.nout),   32'(m_addr[2]));
        chk("a_sout",   32'(ifa.sout),   32'(m_addr[3]));
        chk("a_eout_v", 32'(ifa.eout_v), 32'(m_v[0]));
        chk("a_wout_v", 32'(ifa.wout_v), 32'(m_v[1]));
        chk("a_nout_v", 32'(ifa.nout_v), 32'(m_v[2]));
        chk("a_sout_v", 32'(ifa.sout_v), 32'(m_v[3]));
        chk("a_cnt",    32'(ifa.deflect_cnt), 32'(m_cnt16));
        chk("a_epoch",  32'(ifa.epoch),  32'(m_epoch));
        chk("b_eout",   32'(ifb.eout),   32'(m_addr[0]));
        chk("b_wout",   32'(ifb.wout),   32'(m_addr[1]));
        chk("b_nout_v", 32'(ifb.nout_v), 32'(m_v[2]));
        chk("b_sout_v", 32'(ifb.sout_v), 32'(m_v[3]));
        chk("b_cnt",    32'(ifb.deflect_cnt), 32'(m_cnt4));
        chk("b_epoch",  32'(ifb.epoch),  32'(m_epoch));
    endtask

    // One clock: model the edge, then compare a little after it
    task automatic tick(input logic r);
        rst = r;
        @(posedge clk);
        model_edge(r);
        #1;
        compare_all();
    endtask

    initial begin
        set_slots(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
        tick(1'b1);
        chk("rst_valids", 32'({ifa.eout_v, ifa.wout_v, ifa.nout_v, ifa.sout_v}), 32'd0);
        chk("rst_cnt", 32'(ifa.deflect_cnt), 32'd0);

        // Single flit heading east
        set_slots(4'b0001, 6'b100_110, 6'd0, 6'd0, 6'd0);
        tick(1'b0);
        chk("single_eout", 32'(ifa.eout), 32'(6'b100_110));
        chk("single_eout_v", 32'(ifa.eout_v), 32'd1);
        chk("single_cnt", 32'(ifa.deflect_cnt), 32'd0);

        // Two-way conflict at epoch 0: north wins east, south deflected west
        set_slots(4'b0011, 6'b100_111, 6'b100_101, 6'd0, 6'd0);
        tick(1'b0);
        chk("conf0_eout", 32'(ifa.eout), 32'(6'b100_111));
        chk("conf0_wout", 32'(ifa.wout), 32'(6'b100_101));
        chk("conf0_cnt", 32'(ifa.deflect_cnt), 32'd1);

        // Idle until the epoch advances to 1 (16 edges since reset)
        set_slots(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
        for (int i = 0; i < 14; i++) tick(1'b0);
        chk("epoch1", 32'(ifa.epoch), 32'd1);

        // Same conflict with slot S now first in priority
        set_slots(4'b0011, 6'b100_111, 6'b100_101, 6'd0, 6'd0);
        tick(1'b0);
        chk("conf1_eout", 32'(ifa.eout), 32'(6'b100_101));
        chk("conf1_wout", 32'(ifa.wout), 32'(6'b100_111));
        chk("conf1_cnt", 32'(ifa.deflect_cnt), 32'd2);

        // Full load with a local destination in slot N
        set_slots(4'b1111, 6'b100_100, 6'b110_100, 6'b001_100, 6'b100_000);
        tick(1'b0);
        chk("full_eout", 32'(ifa.eout), 32'(6'b100_100));
        chk("full_nout", 32'(ifa.nout), 32'(6'b110_100));
        chk("full_sout", 32'(ifa.sout), 32'(6'b001_100));
        chk("full_wout", 32'(ifa.wout), 32'(6'b100_000));
        chk("full_cnt", 32'(ifa.deflect_cnt), 32'd3);

        // Saturation on the narrow counter: three deflections per cycle from 3
        set_slots(4'b1111, 6'b100_111, 6'b100_111, 6'b100_111, 6'b100_111);
        for (int i = 0; i < 5; i++) tick(1'b0);
        chk("sat_cnt4", 32'(ifb.deflect_cnt), 32'hF);
        chk("sat_cnt16", 32'(ifa.deflect_cnt), 32'd18);

        // Reset in the middle of random traffic
        for (int i = 0; i < 5; i++) begin set_random(); tick(1'b0); end
        set_random();
        tick(1'b1);
        chk("mid_rst_valids", 32'({ifa.eout_v, ifa.wout_v, ifa.nout_v, ifa.sout_v}), 32'd0);
        chk("mid_rst_cnt", 32'(ifa.deflect_cnt), 32'd0);
        chk("mid_rst_epoch", 32'(ifa.epoch), 32'd0);
        set_slots(4'b0100, 6'd0, 6'd0, 6'b011_100, 6'd0);
        tick(1'b0);
        chk("resume_sout", 32'(ifa.sout), 32'(6'b011_100));
        chk("resume_sout_v", 32'(ifa.sout_v), 32'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            set_random();
            tick(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
